// File: rtl/fpu_result_checker_pkg.sv
// Shared definitions for the FPU result checker.
// Holds the cmp_class encoding and helpers that pull the exponent and
// mantissa fields out of a floating-point word of any width up to MAX_W bits.
// Callers zero-extend their word into word_t and pass the real width and
// exponent width.
package fpu_result_checker_pkg;

    localparam logic [1:0] CLS_MATCH    = 2'b00;
    localparam logic [1:0] CLS_ROUND    = 2'b01;
    localparam logic [1:0] CLS_MISMATCH = 2'b10;
    localparam logic [1:0] CLS_ORPHAN   = 2'b11;

    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    function automatic word_t exp_field(input word_t w, input int width, input int exp_w);
        word_t mask;
        mask = (word_t'(1) << exp_w) - word_t'(1);
        return (w >> (width - 1 - exp_w)) & mask;
    endfunction

    function automatic word_t man_field(input word_t w, input int width, input int exp_w);
        word_t mask;
        mask = (word_t'(1) << (width - 1 - exp_w)) - word_t'(1);
        return w & mask;
    endfunction

    // NaN: exponent all ones with a non-zero mantissa (infinity is not NaN).
    function automatic logic is_nan(input word_t w, input int width, input int exp_w);
        word_t all_ones;
        all_ones = (word_t'(1) << exp_w) - word_t'(1);
        return (exp_field(w, width, exp_w) == all_ones) &&
               (man_field(w, width, exp_w) != '0);
    endfunction

    // Zero of either sign: exponent and mantissa both zero.
    function automatic logic is_zero(input word_t w, input int width, input int exp_w);
        return (exp_field(w, width, exp_w) == '0) &&
               (man_field(w, width, exp_w) == '0);
    endfunction

endpackage

// File: rtl/fpu_result_checker_sync_fifo.sv
// sync_fifo: single-clock queue of expected words.
// Ports: clk/rst (async active-high), clear (sync flush), wr_en/wr_data push
// side, rd_en pops the head, rd_data shows the head combinationally,
// occupancy/full/empty reflect registered state only.
// A push while full is ignored even if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       full,
    output logic                       empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (occupancy == OCC_W'(DEPTH));
    assign empty   = (occupancy == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !clear) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fpu_result_checker.sv
// fpu_result_checker: queues expected FPU results and classifies each DUT
// result against the oldest queued word as match / rounding / mismatch /
// orphan (no expected word queued).
// Ports: CLK, RST (async active-high), clear (sync flush);
// exp_valid/exp_data/exp_ready expected-word push; res_valid/res_data DUT
// results (never back-pressured); cmp_valid/cmp_class/cmp_got/cmp_exp
// one-cycle comparison report; saturating match/round/mismatch/orphan
// counters; occupancy of the queue; sticky overflow_err on a dropped push.
module fpu_result_checker
    import fpu_result_checker_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int EXP_W   = 8,
    parameter int DEPTH   = 16,
    parameter int ULP_TOL = 1,
    parameter int NAN_EQ  = 1,
    parameter int ZERO_EQ = 1,
    parameter int CNT_W   = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    clear,
    input  logic                    exp_valid,
    input  logic [WIDTH-1:0]        exp_data,
    output logic                    exp_ready,
    input  logic                    res_valid,
    input  logic [WIDTH-1:0]        res_data,
    output logic                    cmp_valid,
    output logic [1:0]              cmp_class,
    output logic [WIDTH-1:0]        cmp_got,
    output logic [WIDTH-1:0]        cmp_exp,
    output logic [CNT_W-1:0]        match_cnt,
    output logic [CNT_W-1:0]        round_cnt,
    output logic [CNT_W-1:0]        mismatch_cnt,
    output logic [CNT_W-1:0]        orphan_cnt,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    overflow_err
);
    logic [WIDTH-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .clear     (clear),
        .wr_en     (exp_valid),
        .wr_data   (exp_data),
        .rd_en     (res_valid),
        .rd_data   (head),
        .occupancy (occupancy),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign exp_ready = !fifo_full;

    word_t            got_x;
    word_t            ref_x;
    logic             got_nan, ref_nan, got_zero, ref_zero;
    logic [WIDTH-2:0] got_mag, ref_mag, mag_diff;
    logic             within_ulp;
    logic [1:0]       cls;

    always_comb begin
        got_x = '0;
        ref_x = '0;
        got_x[WIDTH-1:0] = res_data;
        ref_x[WIDTH-1:0] = head;
    end

    assign got_nan  = is_nan(got_x, WIDTH, EXP_W);
    assign ref_nan  = is_nan(ref_x, WIDTH, EXP_W);
    assign got_zero = is_zero(got_x, WIDTH, EXP_W);
    assign ref_zero = is_zero(ref_x, WIDTH, EXP_W);

    // Distance between the sign-less bit patterns; adjacent encodings differ by one ulp.
    assign got_mag    = res_data[WIDTH-2:0];
    assign ref_mag    = head[WIDTH-2:0];
    assign mag_diff   = (got_mag >= ref_mag) ? (got_mag - ref_mag) : (ref_mag - got_mag);
    assign within_ulp = ({1'b0, mag_diff} <= WIDTH'(ULP_TOL));

    always_comb begin
        cls = CLS_MISMATCH;
        if (fifo_empty) begin
            cls = CLS_ORPHAN;
        end else if ((res_data == head) ||
                     ((NAN_EQ != 0) && got_nan && ref_nan) ||
                     ((ZERO_EQ != 0) && got_zero && ref_zero)) begin
            cls = CLS_MATCH;
        end else if ((res_data[WIDTH-1] == head[WIDTH-1]) &&
                     !got_nan && !ref_nan && within_ulp) begin
            cls = CLS_ROUND;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cmp_valid    <= 1'b0;
            cmp_class    <= '0;
            cmp_got      <= '0;
            cmp_exp      <= '0;
            match_cnt    <= '0;
            round_cnt    <= '0;
            mismatch_cnt <= '0;
            orphan_cnt   <= '0;
            overflow_err <= 1'b0;
        end else if (clear) begin
            cmp_valid    <= 1'b0;
            match_cnt    <= '0;
            round_cnt    <= '0;
            mismatch_cnt <= '0;
            orphan_cnt   <= '0;
            overflow_err <= 1'b0;
        end else begin
            cmp_valid <= res_valid;
            if (res_valid) begin
                cmp_class <= cls;
                cmp_got   <= res_data;
                cmp_exp   <= fifo_empty ? '0 : head;
                case (cls)
                    CLS_MATCH:    if (match_cnt    != '1) match_cnt    <= match_cnt    + CNT_W'(1);
                    CLS_ROUND:    if (round_cnt    != '1) round_cnt    <= round_cnt    + CNT_W'(1);
                    CLS_MISMATCH: if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                    default:      if (orphan_cnt   != '1) orphan_cnt   <= orphan_cnt   + CNT_W'(1);
                endcase
            end
            if (exp_valid && fifo_full) overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fpu_result_checker.sv
module tb_fpu_result_checker;

    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        clear = 1'b0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_data = '0;
    logic        exp_ready;
    logic        res_valid = 1'b0;
    logic [31:0] res_data = '0;
    logic        cmp_valid;
    logic [1:0]  cmp_class;
    logic [31:0] cmp_got, cmp_exp;
    logic [31:0] match_cnt, round_cnt, mismatch_cnt, orphan_cnt;
    logic [4:0]  occupancy;
    logic        overflow_err;

    fpu_result_checker dut (
        .CLK(CLK), .RST(RST), .clear(clear),
        .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
        .res_valid(res_valid), .res_data(res_data),
        .cmp_valid(cmp_valid), .cmp_class(cmp_class),
        .cmp_got(cmp_got), .cmp_exp(cmp_exp),
        .match_cnt(match_cnt), .round_cnt(round_cnt),
        .mismatch_cnt(mismatch_cnt), .orphan_cnt(orphan_cnt),
        .occupancy(occupancy), .overflow_err(overflow_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  cls;
        logic [31:0] got;
        logic [31:0] exp;
    } sb_t;

    // Reference model: expected-word queue, scoreboard of pending reports, statistics.
    logic [31:0] mq[$];
    sb_t         sb[$];
    longint      cnt_m[4];
    bit          ovf_m;
    bit          done = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] ref_class(input logic [31:0] g, input logic [31:0] e);
        bit gn, en, gz, ez;
        longint d;
        gn = (g[30:23] == 8'hFF) && (g[22:0] != 0);
        en = (e[30:23] == 8'hFF) && (e[22:0] != 0);
        gz = (g[30:0] == 0);
        ez = (e[30:0] == 0);
        d  = longint'(g[30:0]) - longint'(e[30:0]);
        if (d < 0) d = -d;
        if (g == e || (gn && en) || (gz && ez)) return 2'd0;
        if (g[31] == e[31] && !gn && !en && d <= 1) return 2'd1;
        return 2'd2;
    endfunction

    task automatic model_reset();
        mq.delete();
        sb.delete();
        for (int i = 0; i < 4; i++) cnt_m[i] = 0;
        ovf_m = 0;
    endtask

    task automatic model_update(input bit ev, input logic [31:0] ed,
                                input bit rv, input logic [31:0] rd, input bit clr);
        int  n;
        sb_t s;
        if (clr) begin
            model_reset();
            return;
        end
        n = mq.size();
        if (rv) begin
            if (n > 0) begin
                s.exp = mq.pop_front();
                s.cls = ref_class(rd, s.exp);
            end else begin
                s.exp = 32'h0;
                s.cls = 2'd3;
            end
            s.got = rd;
            sb.push_back(s);
            if (cnt_m[s.cls] < 64'hFFFF_FFFF) cnt_m[s.cls]++;
        end
        if (ev) begin
            if (n < DEPTH) mq.push_back(ed);
            else ovf_m = 1;
        end
    endtask

    task automatic step(input bit ev, input logic [31:0] ed,
                        input bit rv, input logic [31:0] rd, input bit clr);
        @(negedge CLK);
        #1;
        exp_valid = ev; exp_data = ed;
        res_valid = rv; res_data = rd;
        clear = clr;
        @(posedge CLK);
        model_update(ev, ed, rv, rd, clr);
        #1;
        exp_valid = 0; res_valid = 0; clear = 0;
    endtask

    // Monitor: pops the scoreboard whenever a report is due and compares everything visible.
    always @(negedge CLK) begin
        if (!RST && !done) begin
            sb_t s;
            chk("cmp_valid", {63'd0, cmp_valid}, {63'd0, sb.size() != 0});
            if (sb.size() != 0) begin
                s = sb.pop_front();
                if (cmp_valid) begin
                    chk("cmp_class", {62'd0, cmp_class}, {62'd0, s.cls});
                    chk("cmp_got", {32'd0, cmp_got}, {32'd0, s.got});
                    chk("cmp_exp", {32'd0, cmp_exp}, {32'd0, s.exp});
                end
            end
            chk("occupancy", {59'd0, occupancy}, 64'(mq.size()));
            chk("exp_ready", {63'd0, exp_ready}, {63'd0, mq.size() != DEPTH});
            chk("overflow_err", {63'd0, overflow_err}, {63'd0, ovf_m});
            chk("match_cnt", {32'd0, match_cnt}, 64'(cnt_m[0]));
            chk("round_cnt", {32'd0, round_cnt}, 64'(cnt_m[1]));
            chk("mismatch_cnt", {32'd0, mismatch_cnt}, 64'(cnt_m[2]));
            chk("orphan_cnt", {32'd0, orphan_cnt}, 64'(cnt_m[3]));
        end
    end

    function automatic logic [31:0] rand_exp_word();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7F80_0000 | ($urandom() & 32'h007F_FFFF) | 32'h1;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [31:0] rand_res_word(input logic [31:0] head);
        case ($urandom_range(5))
            0:       return head;
            1:       return head + 32'd1;
            2:       return head - 32'd1;
            3:       return head ^ 32'h8000_0000;
            4:       return 32'h7F80_0001 | ($urandom() & 32'h807F_FFFF);
            default: return $urandom();
        endcase
    endfunction

    initial begin
        model_reset();
        repeat (3) @(posedge CLK);
        #3;
        chk("rst_occupancy", {59'd0, occupancy}, 64'd0);
        chk("rst_cmp_valid", {63'd0, cmp_valid}, 64'd0);
        chk("rst_match_cnt", {32'd0, match_cnt}, 64'd0);
        chk("rst_overflow", {63'd0, overflow_err}, 64'd0);
        RST = 1'b0;
        #1;
        chk("rst_exp_ready", {63'd0, exp_ready}, 64'd1);

        // Exact match, then rounding and mismatch.
        step(1, 32'h3F80_0000, 0, 0, 0);
        step(0, 0, 1, 32'h3F80_0000, 0);
        chk("dir_match_class", {62'd0, cmp_class}, 64'd0);
        chk("dir_match_cnt", {32'd0, match_cnt}, 64'd1);
        step(1, 32'h3F80_0000, 0, 0, 0);
        step(0, 0, 1, 32'h3F80_0001, 0);
        chk("dir_round_class", {62'd0, cmp_class}, 64'd1);
        chk("dir_round_cnt", {32'd0, round_cnt}, 64'd1);
        step(1, 32'h3F80_0000, 0, 0, 0);
        step(0, 0, 1, 32'hBF80_0000, 0);
        chk("dir_mismatch_class", {62'd0, cmp_class}, 64'd2);

        // NaN equivalence and signed zero.
        step(1, 32'h7FC0_0000, 0, 0, 0);
        step(0, 0, 1, 32'h7F80_0001, 0);
        chk("dir_nan_class", {62'd0, cmp_class}, 64'd0);
        step(1, 32'h0000_0000, 0, 0, 0);
        step(0, 0, 1, 32'h8000_0000, 0);
        chk("dir_zero_class", {62'd0, cmp_class}, 64'd0);

        // Orphan with same-cycle push into the empty queue.
        step(1, 32'h4000_0000, 1, 32'h1234_5678, 0);
        chk("dir_orphan_class", {62'd0, cmp_class}, 64'd3);
        chk("dir_orphan_exp", {32'd0, cmp_exp}, 64'd0);
        chk("dir_orphan_cnt", {32'd0, orphan_cnt}, 64'd1);
        chk("dir_orphan_occ", {59'd0, occupancy}, 64'd1);
        step(0, 0, 1, 32'h4000_0000, 0);

        // Overflow: 17 pushes into a 16-deep queue, then drain in order.
        for (int i = 0; i < 17; i++) begin
            step(1, 32'h4100_0000 + 32'(i), 0, 0, 0);
            if (i == 15) begin
                chk("dir_full_ready", {63'd0, exp_ready}, 64'd0);
                chk("dir_full_occ", {59'd0, occupancy}, 64'd16);
            end
        end
        chk("dir_ovf", {63'd0, overflow_err}, 64'd1);
        // Push while full together with a pop: push must be dropped.
        step(1, 32'hDEAD_BEEF, 1, 32'h4100_0000, 0);
        chk("dir_full_pop_occ", {59'd0, occupancy}, 64'd15);
        for (int i = 1; i < 16; i++) begin
            step(0, 0, 1, 32'h4100_0000 + 32'(i), 0);
            chk("dir_drain_class", {62'd0, cmp_class}, 64'd0);
        end

        step(0, 0, 0, 0, 1);
        chk("dir_clear_ovf", {63'd0, overflow_err}, 64'd0);
        chk("dir_clear_cnt", {32'd0, match_cnt}, 64'd0);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            bit          ev, rv, clr;
            logic [31:0] ed, rd;
            ev  = ($urandom_range(9) < 6);
            rv  = ($urandom_range(9) < 5);
            clr = ($urandom_range(199) == 0);
            ed  = rand_exp_word();
            rd  = (mq.size() > 0) ? rand_res_word(mq[0]) : $urandom();
            step(ev, ed, rv, rd, clr);
        end

        // Reset mid-operation with five queued words and a report pending.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 32'h4200_0000 + 32'(i), 0, 0, 0);
        step(1, 32'h4200_0005, 1, 32'h4200_0000, 0);
        RST = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_occ", {59'd0, occupancy}, 64'd0);
        chk("mid_rst_cmp_valid", {63'd0, cmp_valid}, 64'd0);
        chk("mid_rst_match_cnt", {32'd0, match_cnt}, 64'd0);
        repeat (2) @(posedge CLK);
        #3;
        RST = 1'b0;
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h4200_0000, 0);
        chk("post_rst_class", {62'd0, cmp_class}, 64'd3);
        @(negedge CLK);
        @(negedge CLK);
        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_result_checker.md
FPU_RESULT_CHECKER -- requirements
Module: fpu_result_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the floating-point word width.
REQ-002 SHALL have parameter EXP_W, default 8, meaning the exponent field width; sign is bit WIDTH-1, exponent is [WIDTH-2 : WIDTH-1-EXP_W], mantissa is the remainder.
REQ-003 SHALL have parameter DEPTH, default 16 (power of two >= 2), meaning expected-value queue depth.
REQ-004 SHALL have parameter ULP_TOL, default 1, meaning the maximum bit-pattern distance classed as a rounding error.
REQ-005 SHALL have parameter NAN_EQ, default 1, meaning any NaN matches any NaN.
REQ-006 SHALL have parameter ZERO_EQ, default 1, meaning +0 matches -0.
REQ-007 SHALL have parameter CNT_W, default 32, meaning statistics counter width.
REQ-008 Ports SHALL be as follows; one clock; reset asynchronous, active-high:
  CLK  in  1  clock, rising edge.
  RST  in  1  asynchronous active-high reset.
  clear  in  1  synchronous flush of queue, counters and sticky flag.
  exp_valid  in  1  expected word present.
  exp_data  in  WIDTH  expected word.
  exp_ready  out  1  queue not full.
  res_valid  in  1  DUT result present.
  res_data  in  WIDTH  DUT result.
  cmp_valid  out  1  one-cycle comparison strobe.
  cmp_class  out  2  00 match, 01 rounding, 10 mismatch, 11 orphan.
  cmp_got  out  WIDTH  result compared.
  cmp_exp  out  WIDTH  expected compared (0 for orphan).
  match_cnt, round_cnt, mismatch_cnt, orphan_cnt  out  CNT_W each  statistics.
  occupancy  out  clog2(DEPTH)+1  queued expected words.
  overflow_err  out  1  sticky; an expected word was dropped.

Function
REQ-009 exp_ready SHALL equal (occupancy != DEPTH), combinationally from registered state.
REQ-010 Push SHALL occur when exp_valid && exp_ready; exp_valid while full SHALL drop the word and set overflow_err.
REQ-011 A result SHALL be consumed every cycle res_valid is high; no backpressure on results.
REQ-012 When res_valid and queue non-empty, the head SHALL be popped and compared; when empty, class SHALL be orphan.
REQ-013 Simultaneous push and pop SHALL both occur, occupancy unchanged; when full, simultaneous pop SHALL NOT free space for the same-cycle push (push is dropped).
REQ-014 A push into an empty queue SHALL NOT be bypassed to a same-cycle result; that result is orphan.
REQ-015 cmp_valid SHALL assert exactly one cycle after each consumed result, with cmp_class/cmp_got/cmp_exp registered alongside; it SHALL be low otherwise.
REQ-016 Match: bit-identical; or NAN_EQ and both NaN (exponent all ones, mantissa non-zero); or ZERO_EQ and both have exponent and mantissa zero.
REQ-017 Rounding: not match, equal sign bits, neither NaN, and unsigned |got[WIDTH-2:0] - exp[WIDTH-2:0]| <= ULP_TOL.
REQ-018 Mismatch: every other non-orphan case.
REQ-019 The counter for cmp_class SHALL increment in the same edge cmp_valid rises; counters SHALL saturate at all ones.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH.
REQ-021 clear SHALL empty the queue, zero counters, clear overflow_err and cmp_valid, and take priority over same-cycle push, pop and compare.

Reset
REQ-022 RST SHALL asynchronously zero all counters, pointers, occupancy, overflow_err, cmp_valid, cmp_class, cmp_got, cmp_exp; exp_ready SHALL read 1 once RST deasserts.
REQ-023 RST asserted mid-operation SHALL discard queued words and any pending comparison; no cmp_valid after release until a new result is consumed.

Structure
REQ-024 A shared package SHALL hold the cmp_class encoding constants and the NaN/zero field-extraction helpers.
REQ-025 The queue SHALL be a sub-module sync_fifo (WIDTH, DEPTH parameters); classification and counters live in the top module.

Verification
REQ-026 Push 0x3F800000, result 0x3F800000 -> next cycle cmp_valid, class 00, match_cnt 1.
REQ-027 Push 0x3F800000, result 0x3F800001 -> class 01, round_cnt 1; result 0xBF800000 -> class 10.
REQ-028 NAN_EQ=1: push 0x7FC00000, result 0x7F800001 -> class 00; push 0x00000000, result 0x80000000 -> class 00.
REQ-029 Result with empty queue -> class 11, cmp_exp 0, orphan_cnt 1; same-cycle push lands, occupancy 1.
REQ-030 Push 17 words with DEPTH=16, no results -> exp_ready 0 after 16th, overflow_err 1, occupancy 16; 16 results then match in push order.
REQ-031 Assert RST with 5 queued and a result in flight -> occupancy 0, cmp_valid stays 0, counters 0.
